// File: rtl/bcd_display_scan_if.sv
// Digit inputs from the stopwatch BCD counter and the scanned seven-segment pins.
// Pure signal bundle: no latency, no backpressure (the display scan free-runs).
interface bcd_display_scan_if;
   logic [2:0] ones;
   logic [3:0] tenths;
   logic [3:0] hundreths;
   logic [3:0] thousandths;
   logic       hold;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_start;

   modport master (
      output ones, tenths, hundreths, thousandths, hold,
      input  an, seg, dp, frame_start
   );

   modport slave (
      input  ones, tenths, hundreths, thousandths, hold,
      output an, seg, dp, frame_start
   );
endinterface

// File: rtl/bcd_display_scan.sv
// Time-multiplexes a frame-coherent snapshot of four BCD digits onto a 4-digit 7-seg display.
// Outputs are registered, 1 cycle after sel/snapshot; no backpressure, the scan free-runs.
module bcd_display_scan #(
   parameter int SCAN_DIV   = 50000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_display_scan_if.slave bus
);
   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic             POL      = ACTIVE_LOW;

   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       sel;
   logic [3:0][3:0]  snap;
   logic             tick;
   logic             wrap;
   logic             wrap_q;
   logic [3:0]       an_hi;
   logic [6:0]       seg_hi;
   logic             dp_hi;

   assign tick = (div_cnt == DIV_LAST);
   assign wrap = tick && (sel == 2'd3);

   // Active-high segment pattern, bit 6 = g ... bit 0 = a; non-BCD codes show a dash.
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         sel     <= 2'd0;
         snap    <= '0;
         wrap_q  <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick)
            sel <= sel + 2'd1;
         // All four digits latch together at the frame wrap so a ripple carry never tears.
         if (wrap && !bus.hold) begin
            snap[0] <= bus.thousandths;
            snap[1] <= bus.hundreths;
            snap[2] <= bus.tenths;
            snap[3] <= {1'b0, bus.ones};
         end
         wrap_q <= wrap;
      end
   end

   always_comb begin
      an_hi  = 4'b0001 << sel;
      seg_hi = decode(snap[sel]);
      dp_hi  = (sel == 2'd3);
   end

   // wrap_q marks the cycle after the wrap, so the pulse lines up with digit 0 of the new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.an          <= {4{POL}};
         bus.seg         <= {7{POL}};
         bus.dp          <= POL;
         bus.frame_start <= 1'b0;
      end else begin
         bus.an          <= an_hi ^ {4{POL}};
         bus.seg         <= seg_hi ^ {7{POL}};
         bus.dp          <= dp_hi ^ POL;
         bus.frame_start <= wrap_q;
      end
   end

   a_an_onehot: assert property (@(posedge clk) disable iff (!rst_n)
                                 $onehot0(bus.an ^ {4{POL}}));
endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench: table of display frames for a slow active-low scan plus hand sequences.
module tb_bcd_display_scan;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n_a;
   logic rst_n_b;

   bcd_display_scan_if ifa ();
   bcd_display_scan_if ifb ();

   bcd_display_scan #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n_a),
      .bus   (ifa.slave)
   );

   bcd_display_scan #(.SCAN_DIV(1), .ACTIVE_LOW(1'b0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n_b),
      .bus   (ifb.slave)
   );

   typedef struct {
      string          name;
      logic [2:0]     ones;
      logic [3:0]     tenths;
      logic [3:0]     hund;
      logic [3:0]     thou;
      logic           hold;
      logic [3:0][6:0] exp_seg;
   } frame_t;

   frame_t frames [7];
   int     n_checks;
   int     n_fail;

   function automatic frame_t mk(input string n, input int o, input int t, input int h,
                                 input int th, input bit hd, input logic [6:0] s0,
                                 input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
      frame_t f;
      f.name       = n;
      f.ones       = 3'(o);
      f.tenths     = 4'(t);
      f.hund       = 4'(h);
      f.thou       = 4'(th);
      f.hold       = hd;
      f.exp_seg[0] = s0;
      f.exp_seg[1] = s1;
      f.exp_seg[2] = s2;
      f.exp_seg[3] = s3;
      return f;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_a(input string tag, input logic [3:0] an, input logic [6:0] seg,
                          input logic dp, input logic fs);
      check({tag, ".an"},  32'(ifa.an),          32'(an));
      check({tag, ".seg"}, 32'(ifa.seg),         32'(seg));
      check({tag, ".dp"},  32'(ifa.dp),          32'(dp));
      check({tag, ".fs"},  32'(ifa.frame_start), 32'(fs));
   endtask

   task automatic check_b(input string tag, input logic [3:0] an, input logic [6:0] seg,
                          input logic dp, input logic fs);
      check({tag, ".an"},  32'(ifb.an),          32'(an));
      check({tag, ".seg"}, 32'(ifb.seg),         32'(seg));
      check({tag, ".dp"},  32'(ifb.dp),          32'(dp));
      check({tag, ".fs"},  32'(ifb.frame_start), 32'(fs));
   endtask

   task automatic set_a(input int o, input int t, input int h, input int th, input bit hd);
      ifa.ones        = 3'(o);
      ifa.tenths      = 4'(t);
      ifa.hundreths   = 4'(h);
      ifa.thousandths = 4'(th);
      ifa.hold        = hd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [6:0] prev3;
      logic [3:0] exp_an;
      int         d;

      n_checks = 0;
      n_fail   = 0;
      rst_n_a  = 1'b0;
      rst_n_b  = 1'b0;
      set_a(3, 4, 5, 6, 1'b0);
      ifb.ones        = 3'd0;
      ifb.tenths      = 4'd0;
      ifb.hundreths   = 4'd0;
      ifb.thousandths = 4'd0;
      ifb.hold        = 1'b0;

      // Expected digits are active-low seg codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 dash=3F.
      frames[0] = mk("scan",    3, 4,  5, 6, 1'b0, 7'h02, 7'h12, 7'h19, 7'h30);
      frames[1] = mk("repeat",  3, 4,  5, 6, 1'b0, 7'h02, 7'h12, 7'h19, 7'h30);
      frames[2] = mk("hold1",   1, 2,  3, 4, 1'b1, 7'h02, 7'h12, 7'h19, 7'h30);
      frames[3] = mk("hold2",   1, 2,  3, 4, 1'b1, 7'h02, 7'h12, 7'h19, 7'h30);
      frames[4] = mk("hold3",   1, 2,  3, 4, 1'b1, 7'h02, 7'h12, 7'h19, 7'h30);
      frames[5] = mk("release", 1, 2,  3, 4, 1'b0, 7'h19, 7'h30, 7'h24, 7'h79);
      frames[6] = mk("badbcd",  1, 12, 3, 4, 1'b0, 7'h19, 7'h30, 7'h3F, 7'h79);

      @(negedge clk);
      @(negedge clk);
      check_a("reset_a", 4'hF, 7'h7F, 1'b1, 1'b0);
      check_b("reset_b", 4'h0, 7'h00, 1'b0, 1'b0);

      rst_n_a = 1'b1;
      step();
      check_a("first", 4'hE, 7'h40, 1'b1, 1'b0);
      repeat (4) step();
      check_a("edge5", 4'hD, 7'h40, 1'b1, 1'b0);
      repeat (10) step();
      check_a("edge15", 4'h7, 7'h40, 1'b0, 1'b0);

      // Inputs go in just before each wrap edge; the next 15 edges show the captured frame.
      prev3 = 7'h40;
      for (int r = 0; r < 7; r++) begin
         set_a(int'(frames[r].ones), int'(frames[r].tenths), int'(frames[r].hund),
               int'(frames[r].thou), frames[r].hold);
         for (int j = 0; j < 16; j++) begin
            step();
            if (j == 0) begin
               check_a({frames[r].name, "_wrap"}, 4'h7, prev3, 1'b0, 1'b0);
            end else begin
               d      = (j - 1) / 4;
               exp_an = ~(4'b0001 << d);
               check_a(frames[r].name, exp_an, frames[r].exp_seg[d],
                       (d == 3) ? 1'b0 : 1'b1, (j == 1) ? 1'b1 : 1'b0);
            end
         end
         prev3 = frames[r].exp_seg[3];
      end

      // Mid-frame input change stays invisible until the following wrap.
      set_a(3, 4, 5, 6, 1'b0);
      step();
      check_a("mid_wrap", 4'h7, 7'h79, 1'b0, 1'b0);
      step();
      check_a("mid_d0", 4'hE, 7'h02, 1'b1, 1'b1);
      repeat (4) step();
      check_a("mid_d1", 4'hD, 7'h12, 1'b1, 1'b0);
      ifa.thousandths = 4'd7;
      ifa.tenths      = 4'd8;
      repeat (4) step();
      check_a("mid_d2_old", 4'hB, 7'h19, 1'b1, 1'b0);
      repeat (7) step();
      check_a("mid_d3_old", 4'h7, 7'h30, 1'b0, 1'b0);
      step();
      check_a("mid_new_d0", 4'hE, 7'h78, 1'b1, 1'b1);
      repeat (8) step();
      check_a("mid_new_d2", 4'hB, 7'h00, 1'b1, 1'b0);

      // Asynchronous reset while frame_start is high.
      repeat (7) step();
      step();
      check_a("pre_rst", 4'hE, 7'h78, 1'b1, 1'b1);
      #2 rst_n_a = 1'b0;
      #1 check_a("async_rst", 4'hF, 7'h7F, 1'b1, 1'b0);
      @(negedge clk);
      rst_n_a = 1'b1;
      step();
      check_a("post_rst", 4'hE, 7'h40, 1'b1, 1'b0);

      // Active-high, one digit per cycle.
      rst_n_b = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         exp_an = 4'b0001 << ((k - 1) % 4);
         check_b("fast", exp_an, 7'h3F, ((k - 1) % 4 == 3) ? 1'b1 : 1'b0,
                 (k > 1 && (k - 1) % 4 == 0) ? 1'b1 : 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
Reads the four BCD stopwatch digits (ones, tenths, hundreths, thousandths) produced by the stopwatch counter and time-multiplexes them onto a 4-digit common-anode seven-segment display. Takes a frame-coherent snapshot of the digits, so a carry rippling between digits never shows a torn value. A hold input freezes the display for lap-time readout. Sits between the BCD counter and the board's display pins.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays lit (must be >= 1); the prescaler width is ceil(log2(SCAN_DIV)), minimum 1.
ACTIVE_LOW, 1, 1 means seg, dp and an are driven active-low (board default); 0 means active-high.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
ones  input  3  BCD seconds digit, 0-7
tenths  input  4  BCD tenths digit
hundreths  input  4  BCD hundredths digit
thousandths  input  4  BCD thousandths digit
hold  input  1  1 = freeze the current snapshot (lap)
an  output  4  digit enables; an[0] = thousandths (rightmost), an[3] = ones
seg  output  7  segments; seg[0] = a through seg[6] = g
dp  output  1  decimal point
frame_start  output  1  one-cycle pulse marking the first output cycle of each new frame

Behaviour:
- Reset (async, rst_n = 0):
  - div_cnt = 0, sel = 0, all snapshot registers = 0.
  - an, seg and dp go inactive: all 1s when ACTIVE_LOW = 1, all 0s otherwise.
  - frame_start = 0.
  - Reset takes effect immediately, including mid-scan or mid-frame.
- Prescaler:
  - div_cnt counts 0 to SCAN_DIV-1, then wraps to 0.
  - tick = (div_cnt == SCAN_DIV-1).
  - SCAN_DIV = 1 gives a tick every cycle.
- Digit select:
  - sel (2 bits) advances on each tick, sequence 0→1→2→3→0.
  - sel 0 = thousandths, 1 = hundreths, 2 = tenths, 3 = ones.
- Snapshot:
  - Loaded on a tick while sel == 3 (the frame wrap) and hold == 0. All four digits are captured in the same cycle.
  - ones is zero-extended to 4 bits.
  - hold is sampled only at the frame wrap. When hold is 1 there, the snapshot keeps its value and scanning continues.
  - Input changes between wraps are never visible.
- Outputs are registered every cycle from the current sel and snapshot, giving 1 cycle latency:
  - an: one-hot of sel in active-high form.
  - seg: decode of snap[sel].
  - dp: 1 only when sel == 3, marking "s.ttt".
  - The first clock edge after reset release drives digit 0 showing "0".
- Decode, active-high, bits g..a:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - Values 10-15 show a dash: 40.
  - When ACTIVE_LOW = 1, an, seg and dp are bitwise inverted.
- frame_start:
  - Registered. High for exactly one cycle, in the output cycle where an first selects digit 0 after a frame wrap.
  - Goes high whether or not the snapshot was updated (hold has no effect on it).
  - Period is 4*SCAN_DIV cycles.
  - Not asserted for the post-reset digit-0 cycle.
- Only one digit is ever enabled at a time. There are no multi-hot an values, including the transition cycles.

Test Plan:
- Reset: drive rst_n low mid-scan, between clock edges → an = 4'b1111, seg = 7'h7F, dp = 1, frame_start = 0 immediately. Release → next edge gives an = 4'b1110, seg = 7'h40 ("0").
- Scan order (SCAN_DIV = 4, ones = 3, tenths = 4, hundreths = 5, thousandths = 6, hold = 0): wrap occurs on the 16th edge after release. From the 17th edge:
  - frame_start = 1 for that single cycle.
  - an = 1110 / seg = 02 for 4 cycles.
  - then an = 1101 / seg = 12.
  - then an = 1011 / seg = 19.
  - then an = 0111 / seg = 30 with dp = 0.
  - The pattern repeats every 16 cycles.
- Hold: with display showing 3.456, set hold = 1 and change inputs to 1.234 → display stays 3.456 for 3 frames. Drop hold → 1.234 appears starting at the next frame_start.
- Mid-frame change: change thousandths from 6 to 7 while sel = 1 → 6 stays on screen until the wrap; 7 appears with the next frame_start.
- Invalid BCD: tenths = 4'hC → on an = 1011, seg = 7'h3F (dash). Other digits are unaffected.
- ACTIVE_LOW = 0, SCAN_DIV = 1, digits 0.000: an rotates 0001→0010→0100→1000 every cycle, seg = 7'h3F, dp = 1 only with an = 1000, and frame_start pulses every 4 cycles.
